// File: rtl/kernel_stream_adapter.sv
// kernel_stream_adapter
// Streaming front/back-end for an ap_ctrl-style kernel wrapper. Arguments
// arriving on a valid/ready stream are queued in a small circular FIFO. One
// kernel invocation is launched per queued argument. The result is captured on
// ap_done together with the number of cycles the invocation took, and both are
// offered on a valid/ready result stream. At most one invocation is in flight.
//
// Ports
//   clk, rst         clock (rising edge) and asynchronous active-low reset
//   arg_data/valid   argument stream in, arg_ready back-pressure out
//   res_data/cycles  captured kernel result and its latency in cycles
//   res_valid        result stream valid, res_ready back-pressure in
//   k_ap_start       kernel start request (argument is k_arg = FIFO head)
//   k_ap_ready       kernel able to accept a start
//   k_ap_done        single-cycle done pulse, k_result valid with it
//   arg_count        FIFO occupancy
//   busy             high while an invocation/result is pending or FIFO non-empty
module kernel_stream_adapter #(
  parameter int DATA_TYPE  = 8,
  parameter int RES_TYPE   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_TYPE-1:0]          arg_data,
  input  logic                          arg_valid,
  output logic                          arg_ready,
  output logic [RES_TYPE-1:0]           res_data,
  output logic [CNT_WIDTH-1:0]          res_cycles,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          k_ap_start,
  input  logic                          k_ap_ready,
  input  logic                          k_ap_done,
  output logic [DATA_TYPE-1:0]          k_arg,
  input  logic [RES_TYPE-1:0]           k_result,
  output logic [$clog2(FIFO_DEPTH):0]   arg_count,
  output logic                          busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [DATA_TYPE-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [PTR_W:0]       r_count;
  logic [CNT_WIDTH-1:0] r_cycleCnt;
  logic [RES_TYPE-1:0]  r_resData;
  logic [CNT_WIDTH-1:0] r_resCycles;

  logic w_push;
  logic w_pop;

  // Ready is forced low during reset; a full FIFO never accepts, even when
  // the head is being popped in the same cycle.
  assign arg_ready  = (r_count < DEPTH_C) && rst;
  assign w_push     = arg_valid && arg_ready;
  assign w_pop      = k_ap_start && k_ap_ready;
  assign k_arg      = r_mem[r_rdPtr];
  assign arg_count  = r_count;
  assign res_data   = r_resData;
  assign res_cycles = r_resCycles;

  // Storage array needs no reset: occupancy alone decides which entries count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= arg_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; done pulses are only meaningful while running.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_pop)     w_nextState = RUN;
      RUN:  if (k_ap_done) w_nextState = HOLD;
      HOLD: if (res_ready) w_nextState = IDLE;
      default:             w_nextState = IDLE;
    endcase
  end

  // FSM outputs. Start is only requested from IDLE, which also guarantees no
  // launch while a result is still waiting in HOLD.
  always_comb begin
    k_ap_start = (r_state == IDLE) && (r_count != '0);
    res_valid  = (r_state == HOLD);
    busy       = (r_state != IDLE) || (r_count != '0);
  end

  // Latency counter starts at 1 on launch so that a done in the first RUN
  // cycle reports 1; it saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycleCnt  <= '0;
      r_resData   <= '0;
      r_resCycles <= '0;
    end else begin
      if (w_pop) begin
        r_cycleCnt <= CNT_WIDTH'(1);
      end else if ((r_state == RUN) && (r_cycleCnt != CNT_MAX)) begin
        r_cycleCnt <= r_cycleCnt + 1'b1;
      end
      if ((r_state == RUN) && k_ap_done) begin
        r_resData   <= k_result;
        r_resCycles <= r_cycleCnt;
      end
    end
  end

endmodule

// File: tb/tb_kernel_stream_adapter.sv
// tb_kernel_stream_adapter
// Drives kernel_stream_adapter with directed and randomized argument/result
// traffic and a small behavioural kernel. A queue-based reference model
// predicts every output each cycle. The DUT is built with a 4-bit cycle
// counter so latency saturation at 15 is reachable.
module tb_kernel_stream_adapter;

  localparam int FIFO_D = 4;
  localparam int CNT_W  = 4;
  localparam int SAT    = 15;

  logic       clk;
  logic       rst;
  logic [7:0] arg_data;
  logic       arg_valid;
  logic       arg_ready;
  logic [7:0] res_data;
  logic [CNT_W-1:0] res_cycles;
  logic       res_valid;
  logic       res_ready;
  logic       k_ap_start;
  logic       k_ap_ready;
  logic       k_ap_done;
  logic [7:0] k_arg;
  logic [7:0] k_result;
  logic [2:0] arg_count;
  logic       busy;

  int checks = 0;
  int failures = 0;

  // Reference model: queued arguments, in-flight flag, pending result.
  logic [7:0] mQ[$];
  bit         mRunning;
  bit         mHasResult;
  int         mRunCycles;
  logic [7:0] mResData;
  int         mResCycles;

  // Behavioural kernel.
  bit         kBusy;
  int         kCnt;
  int         kLat;
  logic [7:0] kArg;

  // Stimulus knobs and collected results.
  int  validProb = 100;
  int  resReadyProb = 100;
  int  kReadyProb = 100;
  int  kFixedLat = 0;
  int  resultMode = 0;
  bit  spurious = 0;
  int  startCount = 0;
  logic [7:0] stimQ[$];
  logic [7:0] obsRes[$];
  int         obsCyc[$];
  logic [7:0] randArgs[$];

  kernel_stream_adapter #(
    .DATA_TYPE(8), .RES_TYPE(8), .FIFO_DEPTH(FIFO_D), .CNT_WIDTH(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .arg_data(arg_data), .arg_valid(arg_valid), .arg_ready(arg_ready),
    .res_data(res_data), .res_cycles(res_cycles), .res_valid(res_valid),
    .res_ready(res_ready),
    .k_ap_start(k_ap_start), .k_ap_ready(k_ap_ready), .k_ap_done(k_ap_done),
    .k_arg(k_arg), .k_result(k_result),
    .arg_count(arg_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] kernelFn(input int mode, input logic [7:0] a);
    case (mode)
      0:       return 8'(32'(a) * 24);
      1:       return 8'(32'(a) * 2);
      default: return a ^ 8'hA5;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModels();
    mQ.delete();
    mRunning = 0;
    mHasResult = 0;
    mRunCycles = 0;
    kBusy = 0;
    kCnt = 0;
    stimQ.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, check the model's
  // predictions, then advance model and kernel as of the next rising edge.
  task automatic applyStimulus();
    bit kDone, expStart, push, pop;
    @(negedge clk);
    if (stimQ.size() != 0 && $urandom_range(0, 99) < validProb) begin
      arg_valid = 1'b1;
      arg_data  = stimQ[0];
    end else begin
      arg_valid = 1'b0;
      arg_data  = 8'($urandom);
    end
    res_ready  = ($urandom_range(0, 99) < resReadyProb);
    k_ap_ready = !kBusy && ($urandom_range(0, 99) < kReadyProb);
    kDone      = kBusy && (kCnt == kLat);
    k_ap_done  = kDone || (spurious && !kBusy && $urandom_range(0, 3) == 0);
    k_result   = kDone ? kernelFn(resultMode, kArg) : 8'($urandom);
    #1;
    expStart = !mRunning && !mHasResult && (mQ.size() != 0);
    checkOutput("arg_ready", 32'(arg_ready), 32'(mQ.size() < FIFO_D));
    checkOutput("arg_count", 32'(arg_count), 32'(mQ.size()));
    checkOutput("k_ap_start", 32'(k_ap_start), 32'(expStart));
    if (expStart) checkOutput("k_arg", 32'(k_arg), 32'(mQ[0]));
    checkOutput("res_valid", 32'(res_valid), 32'(mHasResult));
    if (mHasResult) begin
      checkOutput("res_data", 32'(res_data), 32'(mResData));
      checkOutput("res_cycles", 32'(res_cycles), 32'(mResCycles));
    end
    checkOutput("busy", 32'(busy), 32'(mRunning || mHasResult || mQ.size() != 0));
    if (k_ap_start) startCount++;
    push = arg_valid && (mQ.size() < FIFO_D);
    pop  = expStart && k_ap_ready;
    if (mHasResult && res_ready) begin
      obsRes.push_back(res_data);
      obsCyc.push_back(32'(res_cycles));
      mHasResult = 0;
    end
    if (mRunning) begin
      if (k_ap_done) begin
        mResData   = k_result;
        mResCycles = (mRunCycles > SAT) ? SAT : mRunCycles;
        mRunning   = 0;
        mHasResult = 1;
      end else begin
        mRunCycles++;
      end
    end
    if (pop) begin
      mQ.delete(0);
      mRunning   = 1;
      mRunCycles = 1;
    end
    if (push) begin
      mQ.push_back(arg_data);
      stimQ.delete(0);
    end
    if (k_ap_start && k_ap_ready) begin
      kBusy = 1;
      kCnt  = 1;
      kArg  = k_arg;
      kLat  = (kFixedLat > 0) ? kFixedLat : int'($urandom_range(1, 20));
    end else if (kBusy) begin
      if (kDone) kBusy = 0;
      else kCnt++;
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic resetAndCheck(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    clearModels();
    checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_k_ap_start"}, 32'(k_ap_start), 32'd0);
    checkOutput({tag, "_arg_count"}, 32'(arg_count), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_arg_ready"}, 32'(arg_ready), 32'd0);
    checkOutput({tag, "_res_data"}, 32'(res_data), 32'd0);
    checkOutput({tag, "_res_cycles"}, 32'(res_cycles), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput({tag, "_ready_after"}, 32'(arg_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    arg_data = '0;
    arg_valid = 1'b0;
    res_ready = 1'b0;
    k_ap_ready = 1'b0;
    k_ap_done = 1'b0;
    k_result = '0;
    clearModels();
    resetAndCheck("por");

    // Single run: argument 5, done after 7 RUN cycles, result 120.
    resultMode = 0; kFixedLat = 7; startCount = 0;
    obsRes.delete(); obsCyc.delete();
    stimQ.push_back(8'd5);
    runCycles(20);
    checkOutput("single_starts", 32'(startCount), 32'd1);
    checkOutput("single_nres", 32'(obsRes.size()), 32'd1);
    if (obsRes.size() == 1) begin
      checkOutput("single_data", 32'(obsRes[0]), 32'd120);
      checkOutput("single_cycles", 32'(obsCyc[0]), 32'd7);
    end

    // FIFO full with the kernel stalled, then drain with result = 2*arg.
    kReadyProb = 0; resultMode = 1; kFixedLat = 0;
    obsRes.delete();
    for (int i = 1; i <= 5; i++) stimQ.push_back(8'(i));
    runCycles(8);
    checkOutput("full_count", 32'(arg_count), 32'd4);
    checkOutput("full_ready", 32'(arg_ready), 32'd0);
    checkOutput("full_stalled", 32'(stimQ.size()), 32'd1);
    kReadyProb = 100;
    runCycles(150);
    checkOutput("full_nres", 32'(obsRes.size()), 32'd5);
    for (int i = 0; i < 5 && i < obsRes.size(); i++)
      checkOutput($sformatf("full_res%0d", i), 32'(obsRes[i]), 32'(2 * (i + 1)));

    // Result back-pressure with two arguments waiting.
    resReadyProb = 0; kFixedLat = 4;
    for (int i = 0; i < 3; i++) stimQ.push_back(8'(30 + i));
    runCycles(15);
    startCount = 0;
    runCycles(10);
    checkOutput("bp_no_start", 32'(startCount), 32'd0);
    checkOutput("bp_queued", 32'(arg_count), 32'd2);
    checkOutput("bp_holding", 32'(res_valid), 32'd1);
    resReadyProb = 100;
    applyStimulus();
    applyStimulus();
    checkOutput("bp_relaunch", 32'(k_ap_start), 32'd1);
    runCycles(40);

    // Latency counter saturation.
    kFixedLat = 20; obsCyc.delete();
    stimQ.push_back(8'd9);
    runCycles(30);
    checkOutput("sat_nres", 32'(obsCyc.size()), 32'd1);
    if (obsCyc.size() == 1) checkOutput("sat_cycles", 32'(obsCyc[0]), 32'(SAT));

    // Spurious done pulses in IDLE and HOLD.
    spurious = 1; kFixedLat = 5; resReadyProb = 30; obsRes.delete();
    runCycles(10);
    stimQ.push_back(8'd7);
    stimQ.push_back(8'd8);
    runCycles(60);
    checkOutput("spur_nres", 32'(obsRes.size()), 32'd2);
    spurious = 0; resReadyProb = 100;

    // Reset in the middle of RUN with three arguments queued.
    kFixedLat = 30;
    for (int i = 1; i <= 4; i++) stimQ.push_back(8'(i));
    runCycles(8);
    checkOutput("pre_reset_count", 32'(arg_count), 32'd3);
    resetAndCheck("midrun");

    // Randomized traffic against the scoreboard.
    validProb = 60; resReadyProb = 60; kReadyProb = 70;
    kFixedLat = 0; resultMode = 2; spurious = 1;
    obsRes.delete(); randArgs.delete();
    for (int i = 0; i < 60; i++) begin
      randArgs.push_back(8'($urandom));
      stimQ.push_back(randArgs[i]);
    end
    runCycles(3000);
    checkOutput("rand_nres", 32'(obsRes.size()), 32'(randArgs.size()));
    for (int i = 0; i < randArgs.size() && i < obsRes.size(); i++)
      checkOutput($sformatf("rand_res%0d", i), 32'(obsRes[i]), 32'(kernelFn(2, randArgs[i])));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
